// File: rtl/cordic_op_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : cordic_op_dispatcher
// Brief   : FIFO-buffered request front end that issues one op at a time to a
//           CORDIC core and returns tagged results. Optional WAIT timeout is
//           enabled by defining DISPATCH_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module cordic_op_dispatcher #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [3:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_x,
  input  logic [WIDTH-1:0] i_cmd_y,
  input  logic [WIDTH-1:0] i_cmd_z,
  input  logic [TAG_W-1:0] i_cmd_tag,
  output logic             o_cordic_enable,
  output logic [3:0]       o_cordic_operation,
  output logic [WIDTH-1:0] o_cordic_x,
  output logic [WIDTH-1:0] o_cordic_y,
  output logic [WIDTH-1:0] o_cordic_z,
  input  logic [WIDTH-1:0] i_cordic_result,
  input  logic             i_cordic_done,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic [TAG_W-1:0] o_res_tag,
  output logic [1:0]       o_res_err,
  output logic             o_busy
);

  localparam int         AW           = $clog2(DEPTH);
  localparam logic [3:0] c_OP_DEFAULT = 4'b1111;
  localparam logic [3:0] c_OP_MAX     = 4'd9;
  localparam logic [AW:0] c_PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam bit c_PARAMS_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (TIMEOUT >= 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_rdy_en;
  logic [TAG_W-1:0] r_tag;

  logic [3:0]       r_fifo_op  [DEPTH];
  logic [WIDTH-1:0] r_fifo_x   [DEPTH];
  logic [WIDTH-1:0] r_fifo_y   [DEPTH];
  logic [WIDTH-1:0] r_fifo_z   [DEPTH];
  logic [TAG_W-1:0] r_fifo_tag [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int          CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  logic [CW-1:0] r_wait_cnt;
`endif

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
  // An illegal configuration simply never accepts a request.
  assign o_cmd_ready = c_PARAMS_OK && r_rdy_en && !w_full;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign o_busy      = (r_state != ST_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_op[w_wr_idx]  <= i_cmd_op;
      r_fifo_x[w_wr_idx]   <= i_cmd_x;
      r_fifo_y[w_wr_idx]   <= i_cmd_y;
      r_fifo_z[w_wr_idx]   <= i_cmd_z;
      r_fifo_tag[w_wr_idx] <= i_cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state            <= ST_IDLE;
      r_wr_ptr           <= '0;
      r_rd_ptr           <= '0;
      r_rdy_en           <= 1'b0;
      r_tag              <= '0;
      o_cordic_enable    <= 1'b0;
      o_cordic_operation <= c_OP_DEFAULT;
      o_cordic_x         <= '0;
      o_cordic_y         <= '0;
      o_cordic_z         <= '0;
      o_res_valid        <= 1'b0;
      o_res_data         <= '0;
      o_res_tag          <= '0;
      o_res_err          <= 2'b00;
`ifdef DISPATCH_TIMEOUT_EN
      r_wait_cnt         <= '0;
`endif
    end else begin
      r_rdy_en        <= 1'b1;
      o_cordic_enable <= 1'b0;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_tag    <= r_fifo_tag[w_rd_idx];
            if (r_fifo_op[w_rd_idx] > c_OP_MAX) begin
              // Rejected op: answer directly without touching the core.
              o_res_valid <= 1'b1;
              o_res_data  <= '0;
              o_res_err   <= 2'b01;
              o_res_tag   <= r_fifo_tag[w_rd_idx];
              r_state     <= ST_HOLD;
            end else begin
              o_cordic_operation <= r_fifo_op[w_rd_idx];
              o_cordic_x         <= r_fifo_x[w_rd_idx];
              o_cordic_y         <= r_fifo_y[w_rd_idx];
              o_cordic_z         <= r_fifo_z[w_rd_idx];
              o_cordic_enable    <= 1'b1;
              r_state            <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (i_cordic_done) begin
            o_res_valid <= 1'b1;
            o_res_data  <= i_cordic_result;
            o_res_err   <= 2'b00;
            o_res_tag   <= r_tag;
            r_state     <= ST_HOLD;
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (r_wait_cnt == c_TO_LAST) begin
            o_res_valid <= 1'b1;
            o_res_data  <= '0;
            o_res_err   <= 2'b10;
            o_res_tag   <= r_tag;
            r_state     <= ST_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
          end
`endif
        end
        ST_HOLD: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cordic_op_dispatcher.md
Name: cordic_op_dispatcher

Overview:
- Upstream front end for top_level_calc_cordic.
- Accepts tagged operation requests (op code plus x/y/z operands in Q16.16) over a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the CORDIC core: single-cycle enable pulse, operands held stable, then waits for done.
- Returns each result with its tag and a status code over a valid/ready result interface, decoupling host pacing from CORDIC latency.

Parameters:
- WIDTH, 32: operand/result width, Q16.16 signed.
- DEPTH, 4: command FIFO entries; must be a power of 2, >= 2.
- TAG_W, 4: request tag width.
- TIMEOUT, 64: maximum cycles in WAIT before abort; used only with DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cmd_valid  in  1  request present.
- cmd_ready  out  1  FIFO can accept.
- cmd_op  in  4  operation code, 0..9 per CORDIC op map (SIN=0 … MODH=9).
- cmd_x, cmd_y, cmd_z  in  WIDTH  operands.
- cmd_tag  in  TAG_W  request id.
- cordic_enable  out  1  start pulse to core.
- cordic_operation  out  4  op to core.
- cordic_x, cordic_y, cordic_z  out  WIDTH  operands to core.
- cordic_result  in  WIDTH  core result.
- cordic_done  in  1  core completion.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts.
- res_data  out  WIDTH  result.
- res_tag  out  TAG_W  tag of that request.
- res_err  out  2  00 ok, 01 illegal op, 10 timeout.
- busy  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; FSM to IDLE.
  - cmd_ready=0 while rst=0; 1 from the first edge after release.
  - cordic_enable=0; cordic_operation=4'b1111 (DEFAULT).
  - cordic_x/y/z=0; res_valid=0; res_data=0; res_tag=0; res_err=00; busy=0.
  - Reset mid-operation discards all queued and in-flight requests; no result is emitted for them.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full; no bypass, so a pop in the same cycle does not raise cmd_ready.
  - Pointer wrap is modulo DEPTH with an extra MSB for full/empty.
  - Strict in-order.
- FSM states IDLE, ISSUE, WAIT, HOLD:
  - IDLE:
    - FIFO non-empty: pop, register op/operands/tag onto cordic_* and internal tag.
    - Op > 9: go to HOLD with res_err=01, res_data=0; CORDIC untouched.
    - Otherwise: go to ISSUE.
    - cordic_done is ignored in IDLE.
  - ISSUE:
    - cordic_enable=1 for exactly this one cycle; go to WAIT.
  - WAIT:
    - cordic_done sampled from the cycle after ISSUE onward.
    - On cordic_done=1: res_data<=cordic_result, res_err<=00, go to HOLD.
    - cordic_x/y/z/operation held constant from ISSUE through WAIT.
  - HOLD:
    - res_valid=1; res_data/res_tag/res_err stable until res_valid && res_ready.
    - On handshake: res_valid=0 next cycle, go to IDLE.
- Latency, empty FIFO and idle FSM:
  - Push at edge N → pop at N+1 → cordic_enable high in cycle N+2.
  - cordic_done seen at edge M → res_valid high from M+1.
- Throughput: one request per (CORDIC latency + 4) cycles when res_ready=1.
- busy=0 only in IDLE with empty FIFO.

Optional Feature:
- DISPATCH_TIMEOUT_EN defined:
  - WAIT runs a counter cleared on entry.
  - If TIMEOUT cycles elapse without cordic_done: go to HOLD with res_data=0, res_err=10.
  - A late cordic_done arriving later is ignored, because done is sampled only in WAIT.
  - cordic_done in the same cycle the counter expires wins (res_err=00).
- Not defined:
  - WAIT waits indefinitely; res_err[1] is constant 0; no counter logic.

Test Plan:
- MULT: op=4, x=0x00020000, y=0, z=0x00030000, tag=5; core model asserts done 20 cycles after enable with result 0x00060000 → enable exactly one cycle, 2 cycles after accept; res_data=0x00060000, res_tag=5, res_err=00.
- Backpressure: res_ready=0, push 6 requests back-to-back → 5 accepted (1 in HOLD, 4 queued), then cmd_ready=0; release res_ready → results returned in order with tags 0..4 unchanged.
- Illegal op: op=4'b1010, tag=3 → cordic_enable never asserts; res_valid with res_err=01, res_data=0, res_tag=3.
- Timeout (macro on, TIMEOUT=64): core never asserts done → res_err=10, res_data=0 on cycle 65 of WAIT. A done pulse at cycle 70 is ignored, and the next queued request dispatches normally.
- Reset mid-WAIT with 2 queued: rst=0 for 3 cycles → all outputs at reset values immediately. After release and a core done pulse: no res_valid, busy=0, cmd_ready=1.
- Stable operands: SIN z=0x0000C90F (~0.785 rad) → cordic_x/y/z/operation constant from the enable cycle until done; res_data matches the model value exactly.
